// File: rtl/spi_master.sv
// SPI master (mode 0, MSB first) on the io bus, with TX and RX byte FIFOs.
// Registers: CTRL at base, STATUS at base+1, DATA at base+2.
module spi_master #(
  parameter logic [7:0] SPI_ADDRESS = 8'h1C,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CTRL_ADDR = SPI_ADDRESS;
  localparam logic [7:0] STAT_ADDR = SPI_ADDRESS + 8'd1;
  localparam logic [7:0] DATA_ADDR = SPI_ADDRESS + 8'd2;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  dout_q, dout_d;
  logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic        sck_q, mosi_q, irq_q, miso_bit_q;
  logic [7:0]  shift_q;
  logic [3:0]  hp_q, edge_q;

  logic       en, irq_en, busy;
  logic [3:0] div;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head, status;

  assign en     = ctrl_q[7];
  assign irq_en = ctrl_q[5];
  assign div    = ctrl_q[3:0];
  assign busy   = state_q != IDLE;

  assign tx_empty = tx_wr_q == tx_rd_q;
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = rx_wr_q == rx_rd_q;
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  assign tx_head = tx_mem[tx_rd_q[AW-1:0]];
  assign rx_head = rx_mem[rx_rd_q[AW-1:0]];
  assign status  = {2'b00, overrun_q, busy, rx_empty, rx_full, tx_empty, tx_full};

  assign tx_push = w_en && (address == DATA_ADDR) && !tx_full;
  assign tx_pop  = state_q == LOAD;
  assign rx_push = (state_q == DONE) && !rx_full;
  assign rx_pop  = r_en && (address == DATA_ADDR) && !rx_empty;

  always_comb begin
    ctrl_d    = ctrl_q;
    overrun_d = overrun_q;
    tx_wr_d   = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
    tx_rd_d   = tx_pop  ? tx_rd_q + PTR_ONE : tx_rd_q;
    rx_wr_d   = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
    rx_rd_d   = rx_pop  ? rx_rd_q + PTR_ONE : rx_rd_q;
    dout_d    = 8'h00;
    if (w_en && (address == CTRL_ADDR)) ctrl_d = din & 8'hBF;
    if (w_en && (address == STAT_ADDR)) overrun_d = 1'b0;
    // A byte dropped in the same cycle as a clear still counts as an overrun.
    if ((state_q == DONE) && rx_full) overrun_d = 1'b1;
    if (r_en) begin
      case (address)
        CTRL_ADDR: dout_d = ctrl_q;
        STAT_ADDR: dout_d = status;
        DATA_ADDR: dout_d = rx_empty ? 8'h00 : rx_head;
        default:   dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= 8'h00;
      overrun_q <= 1'b0;
      dout_q    <= 8'h00;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      overrun_q <= overrun_d;
      dout_q    <= dout_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= din;
    if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= shift_q;
  end

  // miso is held in miso_bit_q from the rising edge and enters shift_q on the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      irq_q      <= 1'b0;
      miso_bit_q <= 1'b0;
      shift_q    <= 8'h00;
      hp_q       <= 4'd0;
      edge_q     <= 4'd0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        IDLE: if (en && !tx_empty) state_q <= LOAD;
        LOAD: begin
          if (!en) begin
            state_q <= IDLE;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
          end else begin
            shift_q <= tx_head;
            mosi_q  <= tx_head[7];
            hp_q    <= 4'd0;
            edge_q  <= 4'd0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!en) begin
            state_q <= IDLE;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
          end else if (hp_q == div) begin
            hp_q   <= 4'd0;
            sck_q  <= ~sck_q;
            edge_q <= edge_q + 4'd1;
            if (!sck_q) begin
              miso_bit_q <= miso;
            end else begin
              shift_q <= {shift_q[6:0], miso_bit_q};
              mosi_q  <= shift_q[6];
            end
            if (edge_q == 4'd15) state_q <= DONE;
          end else begin
            hp_q <= hp_q + 4'd1;
          end
        end
        DONE: begin
          irq_q   <= irq_en && !rx_full;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout = dout_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign cs_n = ~ctrl_q[4];
  assign irq  = irq_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback transfers, FIFO limits, overrun, abort and reset.
// Expected received bytes go into a scoreboard queue when written and are popped on DATA reads.
module tb_spi_master;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       irq;
  logic       loopback;
  logic       miso_drv;

  localparam logic [7:0] A_CTRL = 8'h1C;
  localparam logic [7:0] A_STAT = 8'h1D;
  localparam logic [7:0] A_DATA = 8'h1E;

  int total = 0;
  int bad = 0;
  int irq_count = 0;
  logic [7:0] sb[$];

  assign miso = loopback ? mosi : miso_drv;

  spi_master #(.SPI_ADDRESS(8'h1C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n), .irq(irq)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Counts irq pulses, sampled away from the active edge
  always @(negedge clk) if (irq === 1'b1) irq_count++;

  // Hard stop in case something hangs
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0; address = 8'h00; din = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0; address = 8'h00;
    d = dout;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; address = 8'h00; din = 8'h00;
    loopback = 1'b0; miso_drv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (cs_n !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || irq !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got cs_n=%b sck=%b mosi=%b irq=%b dout=%h, expected 1 0 0 0 00",
               cs_n, sck, mosi, irq, dout);
    end
    bus_read(A_CTRL, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL reset_ctrl: got %h expected 00", d); end
    bus_read(A_STAT, d);
    total++; if (d !== 8'h0A) begin bad++; $display("[TB] FAIL reset_status: got %h expected 0a", d); end
    @(negedge clk);
    total++; if (dout !== 8'h00) begin bad++; $display("[TB] FAIL dout_idle: got %h expected 00", dout); end
    bus_read(A_DATA, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", d); end
    bus_read(8'h80, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL unaddressed_read: got %h expected 00", d); end
    bus_write(A_CTRL, 8'h7F);
    bus_read(A_CTRL, d);
    total++; if (d !== 8'h3F) begin bad++; $display("[TB] FAIL ctrl_bit6: got %h expected 3f", d); end
    total++; if (cs_n !== 1'b0) begin bad++; $display("[TB] FAIL cs_assert: got %b expected 0", cs_n); end
    bus_write(A_CTRL, 8'h00);
  endtask

  task automatic test_single_byte();
    logic [7:0] d, exp, bits;
    int rises, toggles, first_rise, last_fall, n0;
    logic prev;
    loopback = 1'b1;
    bus_write(A_CTRL, 8'h90);
    total++; if (cs_n !== 1'b0) begin bad++; $display("[TB] FAIL cs_n_ctrl: got %b expected 0", cs_n); end
    n0 = irq_count;
    sb.push_back(8'hA5);
    bus_write(A_DATA, 8'hA5);
    rises = 0; toggles = 0; first_rise = -1; last_fall = -1; bits = 8'h00; prev = sck;
    for (int c = 0; c < 100 && toggles < 16; c++) begin
      @(posedge clk); #1;
      if (sck !== prev) begin
        toggles++;
        if (sck === 1'b1) begin
          rises++;
          bits = {bits[6:0], mosi};
          if (first_rise < 0) first_rise = c;
        end else begin
          last_fall = c;
        end
      end
      prev = sck;
    end
    total++; if (rises != 8) begin bad++; $display("[TB] FAIL sck_rises: got %0d expected 8", rises); end
    total++; if (bits !== 8'hA5) begin bad++; $display("[TB] FAIL mosi_bits: got %h expected a5", bits); end
    total++;
    if (last_fall - first_rise != 15) begin
      bad++; $display("[TB] FAIL shift_span: got %0d expected 15", last_fall - first_rise);
    end
    repeat (4) @(negedge clk);
    bus_read(A_DATA, d);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    total++; if (d !== exp) begin bad++; $display("[TB] FAIL loop_byte: got %h expected %h", d, exp); end
    bus_read(A_STAT, d);
    total++; if (d !== 8'h0A) begin bad++; $display("[TB] FAIL status_after_byte: got %h expected 0a", d); end
    total++; if (irq_count != n0) begin bad++; $display("[TB] FAIL irq_disabled: got %0d expected %0d", irq_count, n0); end
  endtask

  task automatic test_tx_full();
    logic [7:0] d, exp;
    bus_write(A_CTRL, 8'h10);
    for (int i = 1; i <= 5; i++) begin
      bus_write(A_DATA, 8'(i));
      if (i <= 4) sb.push_back(8'(i));
      if (i >= 4) begin
        bus_read(A_STAT, d);
        total++;
        if (d !== 8'h09) begin bad++; $display("[TB] FAIL tx_full_w%0d: got %h expected 09", i, d); end
      end
    end
    bus_write(A_CTRL, 8'h90);
    repeat (120) @(negedge clk);
    bus_read(A_STAT, d);
    total++; if (d !== 8'h06) begin bad++; $display("[TB] FAIL b2b_status: got %h expected 06", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      total++; if (d !== exp) begin bad++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, d, exp); end
    end
    bus_read(A_STAT, d);
    total++; if (d !== 8'h0A) begin bad++; $display("[TB] FAIL b2b_drained: got %h expected 0a", d); end
  endtask

  task automatic test_overrun();
    logic [7:0] d, exp, v;
    bus_write(A_CTRL, 8'h90);
    for (int i = 0; i < 5; i++) begin
      v = 8'h11 + 8'(i);
      if (i < 4) sb.push_back(v);
      bus_write(A_DATA, v);
      repeat (30) @(negedge clk);
    end
    bus_read(A_STAT, d);
    total++; if (d !== 8'h26) begin bad++; $display("[TB] FAIL overrun_set: got %h expected 26", d); end
    bus_write(A_STAT, 8'h00);
    bus_read(A_STAT, d);
    total++; if (d !== 8'h06) begin bad++; $display("[TB] FAIL overrun_clear: got %h expected 06", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      total++; if (d !== exp) begin bad++; $display("[TB] FAIL ovr_byte%0d: got %h expected %h", i, d, exp); end
    end
    bus_read(A_STAT, d);
    total++; if (d !== 8'h0A) begin bad++; $display("[TB] FAIL ovr_drained: got %h expected 0a", d); end
  endtask

  task automatic test_abort();
    logic [7:0] d, exp;
    int n0;
    bit seen;
    bus_write(A_CTRL, 8'hB3);
    n0 = irq_count;
    sb.push_back(8'h5A);
    bus_write(A_DATA, 8'h5A);
    repeat (100) @(negedge clk);
    total++; if (irq_count != n0 + 1) begin bad++; $display("[TB] FAIL irq_pulse: got %0d expected %0d", irq_count, n0 + 1); end
    bus_read(A_DATA, d);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    total++; if (d !== exp) begin bad++; $display("[TB] FAIL div3_byte: got %h expected %h", d, exp); end
    n0 = irq_count;
    bus_write(A_DATA, 8'h3C);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (sck === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL abort_first_rise: got none expected rise"); end
    repeat (15) @(posedge clk);
    bus_write(A_CTRL, 8'h33);
    @(posedge clk); #1;
    total++; if (sck !== 1'b0 || mosi !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_lines: got sck=%b mosi=%b expected 0 0", sck, mosi);
    end
    repeat (10) @(negedge clk);
    bus_read(A_STAT, d);
    total++; if (d !== 8'h0A) begin bad++; $display("[TB] FAIL abort_status: got %h expected 0a", d); end
    total++; if (irq_count != n0) begin bad++; $display("[TB] FAIL abort_irq: got %0d expected %0d", irq_count, n0); end
    bus_read(A_CTRL, d);
    total++; if (d !== 8'h33) begin bad++; $display("[TB] FAIL abort_ctrl: got %h expected 33", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int toggles;
    bit seen;
    bus_write(A_CTRL, 8'h90);
    bus_write(A_DATA, 8'hC3);
    bus_write(A_DATA, 8'h3C);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (sck === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL rst_mid_rise: got none expected rise"); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (sck !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b0) begin
      bad++; $display("[TB] FAIL rst_mid_lines: got sck=%b cs_n=%b mosi=%b expected 0 1 0", sck, cs_n, mosi);
    end
    @(negedge clk);
    rst = 1'b0;
    toggles = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (sck !== 1'b0) toggles++;
    end
    total++; if (toggles != 0) begin bad++; $display("[TB] FAIL rst_mid_quiet: got %0d expected 0", toggles); end
    bus_read(A_STAT, d);
    total++; if (d !== 8'h0A) begin bad++; $display("[TB] FAIL rst_mid_status: got %h expected 0a", d); end
    bus_read(A_CTRL, d);
    total++; if (d !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_ctrl: got %h expected 00", d); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_byte();
    test_tx_full();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
